step_scheduler: RTL and testbench

- Sequences the x/y stepping datapath (x += 2, y += 1 per asserted select cycle).
- Accepts step-count commands over a valid/ready handshake and drives the datapath's selector for exactly that many un-held cycles.
- After each burst, checks the datapath's post-burst x/y values against the expected arithmetic and raises a sticky error on mismatch.
- Sits between the command/control logic and the datapath instance; holds no arithmetic state of its own beyond counters.

---
 rtl/step_sched_pkg.sv | 17 +
 rtl/step_scheduler_chk.sv | 26 ++
 rtl/step_scheduler.sv | 129 ++++++++++++
 tb/tb_step_scheduler.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/step_sched_pkg.sv
// Shared types and datapath constants for the x/y step scheduler.
// The datapath resets to (X_RST, Y_RST) and adds (X_STEP, Y_STEP) per select.
package step_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        CHECK,
        DONE
    } state_e;

    localparam int X_RST  = 2;
    localparam int Y_RST  = 0;
    localparam int X_STEP = 2;
    localparam int Y_STEP = 1;

endpackage

// File: rtl/step_scheduler_chk.sv
// Combinational invariant check of the datapath's x/y pair.
// x must track y along the stepping line; y must equal start plus steps.
module xy_invariant_chk
    import step_sched_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic [CNT_W-1:0] x,
    input  logic [CNT_W-1:0] y,
    input  logic [CNT_W-1:0] y_start,
    input  logic [CNT_W-1:0] n_steps,
    output logic             mismatch
);

    logic [CNT_W-1:0] x_exp;
    logic [CNT_W-1:0] y_exp;

    // Expected values wrap modulo 2^CNT_W, matching the datapath registers
    always_comb begin
        x_exp = CNT_W'(X_STEP) * y
              + CNT_W'(X_RST - X_STEP * Y_RST);
        y_exp = y_start + CNT_W'(Y_STEP) * n_steps;
        mismatch = (x != x_exp) || (y != y_exp);
    end

endmodule

// File: rtl/step_scheduler.sv
// Issues a commanded number of selector cycles to the x/y datapath,
// then checks the post-burst values and keeps a sticky error flag.
module step_scheduler
    import step_sched_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int TOT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic             hold,
    input  logic             abort,
    input  logic [CNT_W-1:0] x_in,
    input  logic [CNT_W-1:0] y_in,
    output logic             sel_out,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             err,
    input  logic             err_clr,
    output logic [TOT_W-1:0] total_steps
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] ystart_q, ystart_d;
    logic             aborted_q, aborted_d;
    logic             err_q, err_d;
    logic [TOT_W-1:0] total_q, total_d;

    logic [CNT_W-1:0] n_steps;
    logic             mismatch;

    assign sel_out     = (state_q == RUN) && !hold && !abort;
    assign cmd_ready   = (state_q == IDLE);
    assign busy        = !cmd_ready;
    assign done        = (state_q == DONE);
    assign aborted     = aborted_q;
    assign err         = err_q;
    assign total_steps = total_q;

    // Steps actually issued so far in this burst
    assign n_steps = cnt_q - rem_q;

    xy_invariant_chk #(
        .CNT_W(CNT_W)
    ) u_chk (
        .x       (x_in),
        .y       (y_in),
        .y_start (ystart_q),
        .n_steps (n_steps),
        .mismatch(mismatch)
    );

    // Next-state, burst counters, sticky error and lifetime step count
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        ystart_d  = ystart_q;
        aborted_d = 1'b0;
        err_d     = err_q;
        total_d   = total_q + TOT_W'(sel_out);

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    ystart_d = y_in;
                    cnt_d    = cmd_steps;
                    rem_d    = cmd_steps;
                    state_d  = (cmd_steps == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d   = DONE;
                    aborted_d = 1'b1;
                end else if (!hold) begin
                    rem_d = rem_q - 1'b1;
                    if (rem_q == CNT_W'(1)) begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new failure wins over a clear in the same cycle
        if ((state_q == CHECK) && mismatch) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    // State and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            cnt_q     <= '0;
            ystart_q  <= '0;
            aborted_q <= 1'b0;
            err_q     <= 1'b0;
            total_q   <= '0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            ystart_q  <= ystart_d;
            aborted_q <= aborted_d;
            err_q     <= err_d;
            total_q   <= total_d;
        end
    end

endmodule

// File: tb/tb_step_scheduler.sv
// Directed bench for step_scheduler with a behavioural x/y datapath.
// Expected values are hand-computed per burst.
module tb_step_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_steps = '0;
    logic        hold = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  mx;
    logic [7:0]  my;
    logic        sel_out;
    logic        busy;
    logic        done;
    logic        aborted;
    logic        err;
    logic        err_clr = 1'b0;
    logic [15:0] total_steps;

    logic        ld = 1'b0;
    logic [7:0]  ldx = '0;
    logic [7:0]  ldy = '0;

    int n_tests = 0;
    int n_fail  = 0;

    int   sels;
    int   dk;
    logic ab;
    int   dcnt;

    always #5 clk = ~clk;

    step_scheduler #(
        .CNT_W(8),
        .TOT_W(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_steps  (cmd_steps),
        .hold       (hold),
        .abort      (abort),
        .x_in       (mx),
        .y_in       (my),
        .sel_out    (sel_out),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .err        (err),
        .err_clr    (err_clr),
        .total_steps(total_steps)
    );

    // Datapath model: x += 2, y += 1 per select; bench may load it
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mx <= 8'd2;
            my <= 8'd0;
        end else if (ld) begin
            mx <= ldx;
            my <= ldy;
        end else if (sel_out) begin
            mx <= mx + 8'd2;
            my <= my + 8'd1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic load_xy(input logic [7:0] x, input logic [7:0] y);
        @(negedge clk);
        ldx = x;
        ldy = y;
        ld  = 1'b1;
        @(negedge clk);
        ld  = 1'b0;
    endtask

    // k=1 is the first cycle after the accepting edge
    task automatic burst(input logic [7:0] n, input int h0, input int hn,
                         input int ab_at, input int clr_k,
                         output int s, output int d, output logic a);
        s = 0;
        d = -1;
        a = 1'b0;
        @(negedge clk);
        chk("ready_pre", {31'd0, cmd_ready}, 1);
        cmd_steps = n;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            hold    = (k >= h0) && (k < h0 + hn);
            abort   = (ab_at > 0) && (s == ab_at);
            err_clr = (k == clr_k);
            #1;
            if (sel_out) s++;
            if (done) begin
                d = k;
                a = aborted;
                break;
            end
            @(negedge clk);
        end
        hold    = 1'b0;
        abort   = 1'b0;
        err_clr = 1'b0;
        if (d < 0) chk("done_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        #12;
        chk("rst_ready", {31'd0, cmd_ready}, 1);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_sel", {31'd0, sel_out}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_abt", {31'd0, aborted}, 0);
        chk("rst_err", {31'd0, err}, 0);
        chk("rst_total", {16'd0, total_steps}, 0);
        @(negedge clk);
        rst = 1'b0;

        // 3 steps, no hold
        burst(8'd3, 0, 0, 0, 0, sels, dk, ab);
        chk("t1_sels", sels, 3);
        chk("t1_donek", dk, 5);
        chk("t1_abt", {31'd0, ab}, 0);
        chk("t1_x", {24'd0, mx}, 8);
        chk("t1_y", {24'd0, my}, 3);
        chk("t1_err", {31'd0, err}, 0);
        chk("t1_total", {16'd0, total_steps}, 3);
        @(negedge clk);
        #1;
        chk("t1_pulse", {31'd0, done}, 0);
        chk("t1_ready", {31'd0, cmd_ready}, 1);

        // 4 steps with 2 held cycles
        load_xy(8'd2, 8'd0);
        burst(8'd4, 2, 2, 0, 0, sels, dk, ab);
        chk("t2_sels", sels, 4);
        chk("t2_donek", dk, 8);
        chk("t2_x", {24'd0, mx}, 10);
        chk("t2_y", {24'd0, my}, 4);
        chk("t2_err", {31'd0, err}, 0);
        chk("t2_total", {16'd0, total_steps}, 7);

        // zero-step command
        burst(8'd0, 0, 0, 0, 0, sels, dk, ab);
        chk("t3_sels", sels, 0);
        chk("t3_donek", dk, 1);
        chk("t3_abt", {31'd0, ab}, 0);
        chk("t3_total", {16'd0, total_steps}, 7);

        // abort after second step
        burst(8'd5, 0, 0, 2, 0, sels, dk, ab);
        chk("t4_sels", sels, 2);
        chk("t4_donek", dk, 4);
        chk("t4_abt", {31'd0, ab}, 1);
        chk("t4_y", {24'd0, my}, 6);
        chk("t4_err", {31'd0, err}, 0);
        chk("t4_total", {16'd0, total_steps}, 9);
        @(negedge clk);
        #1;
        chk("t4_abt_clr", {31'd0, aborted}, 0);

        // corrupted x sets sticky error
        load_xy(8'd7, 8'd0);
        burst(8'd1, 0, 0, 0, 0, sels, dk, ab);
        chk("t5_err_set", {31'd0, err}, 1);
        load_xy(8'd2, 8'd0);
        burst(8'd2, 0, 0, 0, 0, sels, dk, ab);
        chk("t5_err_stky", {31'd0, err}, 1);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        #1;
        chk("t5_err_clr", {31'd0, err}, 0);
        load_xy(8'd7, 8'd0);
        burst(8'd1, 0, 0, 0, 2, sels, dk, ab);
        chk("t5_set_win", {31'd0, err}, 1);
        chk("t5_total", {16'd0, total_steps}, 13);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;

        // y wraps through 255
        load_xy(8'd246, 8'd250);
        burst(8'd10, 0, 0, 0, 0, sels, dk, ab);
        chk("t6_sels", sels, 10);
        chk("t6_x", {24'd0, mx}, 10);
        chk("t6_y", {24'd0, my}, 4);
        chk("t6_err", {31'd0, err}, 0);
        chk("t6_total", {16'd0, total_steps}, 23);

        // reset in the middle of a burst
        @(negedge clk);
        cmd_steps = 8'd5;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        chk("t7_busy", {31'd0, busy}, 1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("t7_sel", {31'd0, sel_out}, 0);
        chk("t7_ready", {31'd0, cmd_ready}, 1);
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (done) dcnt++;
            @(negedge clk);
        end
        chk("t7_nodone", dcnt, 0);
        chk("t7_ready2", {31'd0, cmd_ready}, 1);
        chk("t7_total", {16'd0, total_steps}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
